// File: rtl/uart_tx_periph.sv
// rtl/uart_tx_periph.sv - memory-mapped 8N1 UART transmitter with TX FIFO
//
// Ports:
//   clk      clock
//   rst_n    synchronous active-low reset
//   sel      address decoder hit for this block
//   addr     byte offset (bits [1:0] ignored): 0x0 TXDATA, 0x4 STATUS, 0x8 BAUD_DIV, 0xC CTRL
//   wdata    store data, CPU lane layout
//   wenable  byte write enables
//   rdata    combinational read data, 0 when sel=0
//   txd      registered serial output, idle high
//   irq      registered level interrupt: irq_en & FIFO empty & transmitter idle
//
// Optional feature macro: UART_TX_PARITY_EN adds CTRL[1] parity_en, CTRL[2] parity_odd
// and a PARITY bit between the last data bit and the stop bit.
module uart_tx_periph #(
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd867
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sel,
  input  logic [3:0]  addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  wenable,
  output logic [31:0] rdata,
  output logic        txd,
  output logic        irq
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  // register file
  logic [15:0] baud_div;
  logic        irq_en;
  logic        overflow;
`ifdef UART_TX_PARITY_EN
  logic        parity_en;
  logic        parity_odd;
`endif

  // FIFO
  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wptr, rptr;
  logic [CW-1:0] count;
  logic          empty, full, push, pop, wr_txdata, ovf_set, ovf_clr;
  logic [7:0]    head;

  // serializer
  state_t      state_q, state_d;
  logic [2:0]  bit_q, bit_d;
  logic [15:0] baud_q, baud_d;
  logic [7:0]  sh_q, sh_d;
  logic        line_d;
  logic        baud_done;
`ifdef UART_TX_PARITY_EN
  logic        par_q, par_d;
`endif

  logic wr;
  logic unused_bits;

  assign unused_bits = ^{wdata[31:16], addr[1:0]};

  assign wr        = sel && (wenable != 4'd0);
  assign wr_txdata = wr && (addr[3:2] == 2'd0) && wenable[0];
  assign ovf_clr   = wr && (addr[3:2] == 2'd1) && wenable[0] && wdata[3];

  assign empty = (count == '0);
  assign full  = (count == CW'(FIFO_DEPTH));
  assign head  = mem[rptr];
  assign pop   = (state_q == S_IDLE) && !empty;
  // a pop in the same cycle frees the slot, so a push into a full FIFO is still taken
  assign push    = wr_txdata && (!full || pop);
  assign ovf_set = wr_txdata && full && !pop;

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= wdata[7:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wptr <= wptr + PW'(1);
      if (pop)  rptr <= rptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      // set has priority over a simultaneous clear
      if (ovf_set)      overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      baud_div   <= DEFAULT_DIV;
      irq_en     <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_en  <= 1'b0;
      parity_odd <= 1'b0;
`endif
    end else if (wr) begin
      if (addr[3:2] == 2'd2) begin
        if (wenable[0]) baud_div[7:0]  <= wdata[7:0];
        if (wenable[1]) baud_div[15:8] <= wdata[15:8];
      end
      if (addr[3:2] == 2'd3 && wenable[0]) begin
        irq_en     <= wdata[0];
`ifdef UART_TX_PARITY_EN
        parity_en  <= wdata[1];
        parity_odd <= wdata[2];
`endif
      end
    end
  end

  always_comb begin
    rdata = '0;
    if (sel) begin
      case (addr[3:2])
        2'd1: begin
          rdata[0]      = empty;
          rdata[1]      = full;
          rdata[2]      = (state_q != S_IDLE);
          rdata[3]      = overflow;
          rdata[8 +: CW] = count;
        end
        2'd2: rdata[15:0] = baud_div;
        2'd3: begin
          rdata[0] = irq_en;
`ifdef UART_TX_PARITY_EN
          rdata[1] = parity_en;
          rdata[2] = parity_odd;
`endif
        end
        default: rdata = '0;
      endcase
    end
  end

  assign baud_done = (baud_q == 16'd0);

  // line_d is the level for the current state; txd registers it, so the line
  // trails the state by one clock (write at k -> pop at k+1 -> start bit at k+2)
  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    baud_d  = baud_q;
    sh_d    = sh_q;
    line_d  = 1'b1;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          sh_d    = head;
          baud_d  = baud_div;
          state_d = S_START;
`ifdef UART_TX_PARITY_EN
          par_d   = (^head) ^ parity_odd;
`endif
        end
      end
      S_START: begin
        line_d = 1'b0;
        if (baud_done) begin
          state_d = S_DATA;
          bit_d   = 3'd0;
          baud_d  = baud_div;
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
      S_DATA: begin
        line_d = sh_q[0];
        if (baud_done) begin
          baud_d = baud_div;
          sh_d   = {1'b0, sh_q[7:1]};
          if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = parity_en ? S_PARITY : S_STOP;
`else
            state_d = S_STOP;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        line_d = par_q;
        if (baud_done) begin
          state_d = S_STOP;
          baud_d  = baud_div;
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
`endif
      S_STOP: begin
        line_d = 1'b1;
        if (baud_done) state_d = S_IDLE;
        else           baud_d  = baud_q - 16'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      bit_q   <= 3'd0;
      baud_q  <= 16'd0;
      sh_q    <= 8'd0;
      txd     <= 1'b1;
      irq     <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      baud_q  <= baud_d;
      sh_q    <= sh_d;
      txd     <= line_d;
      irq     <= irq_en && empty && (state_q == S_IDLE);
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_periph.sv
// tb/tb_uart_tx_periph.sv - self-checking bench for uart_tx_periph
module tb_uart_tx_periph;

  logic        clk = 1'b0;
  logic        rst_n, sel;
  logic [3:0]  addr, wenable;
  logic [31:0] wdata, rdata;
  logic        txd, irq;

  always #5 clk = ~clk;

  uart_tx_periph #(.FIFO_DEPTH(8), .DEFAULT_DIV(16'd867)) dut (
    .clk(clk), .rst_n(rst_n), .sel(sel), .addr(addr), .wdata(wdata),
    .wenable(wenable), .rdata(rdata), .txd(txd), .irq(irq)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // reference model: bytes accepted but not yet seen on the line, and register shadows
  logic [7:0]  q_m[$];
  logic [15:0] div_m = 16'd867;
  logic        irq_en_m = 1'b0, par_en_m = 1'b0, par_odd_m = 1'b0;

  // line decoder state
  bit          in_frame = 0;
  bit          pend_prev = 0;
  int          bit_idx, cyc, bit_len, nbits, frame_len;
  int          idle_cnt = 2, frames_done = 0, last_frame_len = 0;
  logic [10:0] exp_bits, cur_bits, last_bits;

  // every cycle: the line must follow the 8N1(+P) frame built from the next queued byte,
  // each bit held BAUD_DIV+1 clocks, irq low throughout the frame
  always @(negedge clk) begin
    logic [7:0] b;
    if (!rst_n) begin
      in_frame  = 0;
      idle_cnt  = 2;
      pend_prev = 0;
    end else begin
      if (in_frame && cyc == bit_len) begin
        bit_idx++;
        cyc     = 0;
        bit_len = int'(div_m) + 1;
        if (bit_idx == nbits) begin
          in_frame       = 0;
          idle_cnt       = 0;
          frames_done++;
          last_frame_len = frame_len;
          last_bits      = cur_bits;
        end
      end
      if (!in_frame) begin
        if (txd === 1'b0) begin
          if (q_m.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL unexpected_start: got start bit expected idle line at %0t", $time);
            b = 8'h00;
          end else begin
            b = q_m.pop_front();
          end
          check("idle_gap_min", 32'(idle_cnt >= 1), 32'd1);
          if (pend_prev) check("idle_gap_b2b", 32'(idle_cnt), 32'd1);
          pend_prev   = (q_m.size() != 0);
          exp_bits    = '1;
          exp_bits[0] = 1'b0;
          exp_bits[8:1] = b;
          nbits       = 10;
          if (par_en_m) begin
            exp_bits[9] = (^b) ^ par_odd_m;
            nbits       = 11;
          end
          in_frame  = 1;
          bit_idx   = 0;
          cyc       = 0;
          bit_len   = int'(div_m) + 1;
          frame_len = 0;
          cur_bits  = '1;
        end else begin
          idle_cnt++;
        end
      end
      if (in_frame) begin
        check("txd_bit", 32'(txd), 32'(exp_bits[bit_idx]));
        check("irq_busy", 32'(irq), 32'd0);
        if (cyc == 0) cur_bits[bit_idx] = txd;
        cyc++;
        frame_len++;
      end
    end
  end

  task automatic model_update(input logic [3:0] a, input logic [31:0] d, input logic [3:0] we);
    if (we == 4'd0) return;
    case (a[3:2])
      2'd0: if (we[0]) q_m.push_back(d[7:0]);
      2'd2: begin
        if (we[0]) div_m[7:0]  = d[7:0];
        if (we[1]) div_m[15:8] = d[15:8];
      end
      2'd3: if (we[0]) begin
        irq_en_m = d[0];
`ifdef UART_TX_PARITY_EN
        par_en_m  = d[1];
        par_odd_m = d[2];
`endif
      end
      default: ;
    endcase
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] we);
    @(negedge clk);
    sel = 1'b1; addr = a; wdata = d; wenable = we;
    @(posedge clk);
    #1 model_update(a, d, we);
    @(negedge clk);
    sel = 1'b0; wenable = 4'd0;
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
    @(negedge clk);
    sel = 1'b1; addr = a; wenable = 4'd0;
    #1 d = rdata;
    sel = 1'b0;
  endtask

  // back-to-back TXDATA stores; only the first n_acc are expected to be accepted
  task automatic burst(input int n, input int n_acc, input int seed);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      sel = 1'b1; addr = 4'h0; wenable = 4'h1; wdata = 32'(8'(seed + i * 37));
      @(posedge clk);
      #1 if (i < n_acc) q_m.push_back(8'(seed + i * 37));
    end
    @(negedge clk);
    sel = 1'b0; wenable = 4'd0;
  endtask

  task automatic wait_frames(input int target, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #1 if (frames_done >= target) return;
    end
    n_cmp++; n_err++;
    $display("FAIL wait_frames: got %0d frames expected %0d", frames_done, target);
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #1 if (q_m.size() == 0 && !in_frame) return;
    end
    n_cmp++; n_err++;
    $display("FAIL wait_drain: got %0d queued expected 0", q_m.size());
  endtask

  task automatic wait_bit(input int idx, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #1 if (in_frame && bit_idx == idx && cyc == 1) return;
    end
    n_cmp++; n_err++;
    $display("FAIL wait_bit: got bit %0d expected %0d", bit_idx, idx);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    int f0;
    rst_n = 1'b0; sel = 1'b0; addr = 4'h0; wdata = '0; wenable = 4'h0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // reset state and idle line
    bus_read(4'h4, r); check("status_reset", r, 32'h0000_0001);
    bus_read(4'h8, r); check("baud_reset", r, 32'd867);
    bus_read(4'hC, r); check("ctrl_reset", r, 32'd0);
    bus_read(4'h0, r); check("txdata_read", r, 32'd0);
    @(negedge clk); sel = 1'b0; addr = 4'h4; #1 check("rdata_unsel", rdata, 32'd0);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      check("idle_txd", 32'(txd), 32'd1);
      check("idle_irq", 32'(irq), 32'd0);
    end

    // CTRL reserved bits read 0
    bus_write(4'hC, 32'hFFFF_FFFF, 4'hF);
    bus_read(4'hC, r); check("ctrl_rw", r, {29'd0, par_odd_m, par_en_m, irq_en_m});
    bus_write(4'hC, 32'h0, 4'h1);

    // latency and 0x55 waveform at BAUD_DIV=3
    bus_write(4'h8, 32'h0000_0003, 4'h3);
    @(negedge clk);
    sel = 1'b1; addr = 4'h0; wdata = 32'h55; wenable = 4'h1;
    @(posedge clk);
    #1 q_m.push_back(8'h55);
    sel = 1'b0; wenable = 4'h0;
    check("lat_k", 32'(txd), 32'd1);
    @(posedge clk); #1 check("lat_k1", 32'(txd), 32'd1);
    @(posedge clk); #1 check("lat_k2", 32'(txd), 32'd0);
    f0 = frames_done;
    wait_frames(f0 + 1, 200);
    check("bits_0x55", 32'(last_bits[9:0]), 32'b10_1010_1010);
    check("len_0x55", 32'(last_frame_len), 32'd40);

    // BAUD_DIV=0 burst of 9: first byte popped concurrently, so all 9 fit
    bus_write(4'h8, 32'h0, 4'h3);
    burst(9, 9, 8'h11);
    bus_read(4'h4, r); check("ovf_div0", 32'(r[3]), 32'd0);
    wait_drain(2000);

    // BAUD_DIV=100 burst of 10: one popped, 8 in FIFO, 10th overflows
    bus_write(4'h8, 32'd100, 4'h3);
    burst(10, 9, 8'h3C);
    bus_read(4'h4, r); check("status_ovf", r, 32'h0000_080E);
    bus_write(4'h4, 32'h8, 4'h1);
    bus_read(4'h4, r); check("status_ovf_clr", r, 32'h0000_0806);
    wait_drain(15000);

    // irq on transmitter idle
    bus_write(4'h8, 32'd1, 4'h3);
    bus_write(4'hC, 32'h1, 4'h1);
    @(negedge clk); #1 check("irq_idle_en", 32'(irq), 32'd1);
    f0 = frames_done;
    bus_write(4'h0, 32'hA3, 4'h1);
    wait_frames(f0 + 1, 200);
    check("irq_after_frame", 32'(irq), 32'd1);
    bus_write(4'hC, 32'h0, 4'h1);
    check("irq_hold", 32'(irq), 32'd1);
    @(negedge clk); #1 check("irq_drop", 32'(irq), 32'd0);

    // BAUD_DIV 3 -> 7 during data bit 2
    bus_write(4'h8, 32'd3, 4'h3);
    f0 = frames_done;
    bus_write(4'h0, 32'h55, 4'h1);
    wait_bit(3, 200);
    bus_write(4'h8, 32'd7, 4'h3);
    wait_frames(f0 + 1, 300);
    check("len_midchange", 32'(last_frame_len), 32'd64);

    // reset during data bit 4
    bus_write(4'h8, 32'd3, 4'h3);
    bus_write(4'h0, 32'hC6, 4'h1);
    wait_bit(5, 200);
    @(negedge clk); rst_n = 1'b0;
    @(posedge clk); #1 check("rst_txd", 32'(txd), 32'd1);
    @(negedge clk);
    @(negedge clk); rst_n = 1'b1;
    q_m.delete(); div_m = 16'd867; irq_en_m = 1'b0; par_en_m = 1'b0; par_odd_m = 1'b0;
    bus_read(4'h4, r); check("rst_status", r, 32'h0000_0001);
    bus_read(4'h8, r); check("rst_baud", r, 32'd867);

`ifdef UART_TX_PARITY_EN
    bus_write(4'h8, 32'd3, 4'h3);
    bus_write(4'hC, 32'h3, 4'h1);
    bus_write(4'hC, 32'h6, 4'h1);
    f0 = frames_done;
    bus_write(4'h0, 32'h07, 4'h1);
    wait_frames(f0 + 1, 300);
    check("parity_odd_07", 32'(last_bits[9]), 32'd0);
    check("parity_stop", 32'(last_bits[10]), 32'd1);
    check("parity_len", 32'(last_frame_len), 32'd44);
    bus_write(4'hC, 32'h2, 4'h1);
    f0 = frames_done;
    bus_write(4'h0, 32'h07, 4'h1);
    wait_frames(f0 + 1, 300);
    check("parity_even_07", 32'(last_bits[9]), 32'd1);
    bus_write(4'hC, 32'h0, 4'h1);
`endif

    // randomized traffic
    for (int it = 0; it < 30; it++) begin
      logic [3:0] we;
      int nb;
      we = 4'($urandom_range(1, 3));
      bus_write(4'h8, {16'($urandom), 8'h00, 8'($urandom_range(0, 5))}, we);
      bus_read(4'h8, r); check("rand_baud", r, {16'd0, div_m});
      nb = $urandom_range(1, 5);
      for (int j = 0; j < nb; j++) begin
        we = 4'($urandom);
        bus_write(4'h0, $urandom, we);
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      bus_read(4'h0, r); check("rand_txdata_rd", r, 32'd0);
      wait_drain(3000);
      bus_read(4'h4, r); check("rand_status_idle", r, 32'h0000_0001);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
